// File: rtl/fp_align_pkg.sv
// Shared constants and helpers for the FP exponent-compare / alignment front end.
package fp_align_pkg;

  localparam int unsigned GRS_BITS = 3;

  // Effective exponent (denormals and zero behave as exponent 1) plus the hidden bit.
  function automatic logic [31:0] eff_exp(input logic [31:0] e, output logic hidden);
    hidden = (e != '0);
    return hidden ? e : 32'd1;
  endfunction

endpackage

// File: rtl/align_shift_sticky.sv
// Right shifter that folds every bit shifted past bit 0 into the sticky LSB,
// saturating to a pure sticky result when the shift covers the whole word.
module align_shift_sticky #(
  parameter int unsigned W  = 27,
  parameter int unsigned SW = 9
) (
  input  logic [W-1:0]  in_val,
  input  logic [SW-1:0] sh,
  output logic [W-1:0]  out_val
);

  logic [W-1:0] shifted;
  logic         sticky;

  always_comb begin
    shifted = '0;
    sticky  = 1'b0;
    if (32'(sh) >= W) begin
      sticky = |in_val;
    end else begin
      shifted = in_val >> sh;
      // Bits 0..sh all collapse into the result's LSB.
      for (int unsigned i = 0; i < W; i++) begin
        if (i <= 32'(sh)) sticky = sticky | in_val[i];
      end
    end
    out_val = {shifted[W-1:1], shifted[0] | sticky};
  end

endmodule

// File: rtl/exp_align_pipe.sv
// Two-stage exponent compare / significand alignment with valid-ready flow control.
module exp_align_pipe
  import fp_align_pkg::*;
#(
  parameter int unsigned EX_WIDTH    = 8,
  parameter int unsigned MAN_WIDTH   = 23,
  parameter bit          SWAP_ON_TIE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EX_WIDTH-1:0]     ea,
  input  logic [EX_WIDTH-1:0]     eb,
  input  logic [MAN_WIDTH-1:0]    fa,
  input  logic [MAN_WIDTH-1:0]    fb,
  input  logic                    sa,
  input  logic                    sb,
  input  logic                    op_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EX_WIDTH-1:0]     max_exp,
  output logic [EX_WIDTH:0]       d,
  output logic                    swapped,
  output logic                    eff_sub,
  output logic                    sign_big,
  output logic [MAN_WIDTH:0]      m_big,
  output logic [MAN_WIDTH+3:0]    m_small
);

  localparam int unsigned SIG_W = MAN_WIDTH + 1;
  localparam int unsigned AL_W  = SIG_W + GRS_BITS;

  typedef struct packed {
    logic [EX_WIDTH-1:0] e_big;
    logic [EX_WIDTH:0]   d;
    logic                swapped;
    logic                eff_sub;
    logic                sign_big;
    logic [SIG_W-1:0]    m_big;
    logic [SIG_W-1:0]    m_small_unshifted;
  } s1_t;

  typedef struct packed {
    logic [EX_WIDTH-1:0] e_big;
    logic [EX_WIDTH:0]   d;
    logic                swapped;
    logic                eff_sub;
    logic                sign_big;
    logic [SIG_W-1:0]    m_big;
    logic [AL_W-1:0]     m_small;
  } s2_t;

  logic                v1_q, v1_d, v2_q, v2_d, init_q;
  s1_t                 r1_q, r1_d, s1_new;
  s2_t                 r2_q, r2_d;
  logic                load1, adv2;
  logic                ha, hb, swap;
  logic [EX_WIDTH-1:0] eeff_a, eeff_b;
  logic [SIG_W-1:0]    sig_a, sig_b;
  logic [AL_W-1:0]     aligned;

  assign in_ready  = init_q && (!v1_q || !v2_q || out_ready);
  assign load1     = in_valid && in_ready;
  assign adv2      = v1_q && (!v2_q || out_ready);

  always_comb begin
    ha     = 1'b0;
    hb     = 1'b0;
    eeff_a = EX_WIDTH'(eff_exp(32'(ea), ha));
    eeff_b = EX_WIDTH'(eff_exp(32'(eb), hb));
    sig_a  = {ha, fa};
    sig_b  = {hb, fb};
    swap   = (eeff_b > eeff_a) ||
             (SWAP_ON_TIE && (eeff_b == eeff_a) && (sig_b > sig_a));

    s1_new                   = '0;
    s1_new.e_big             = swap ? eeff_b : eeff_a;
    s1_new.d                 = {1'b0, swap ? (eeff_b - eeff_a) : (eeff_a - eeff_b)};
    s1_new.swapped           = swap;
    s1_new.eff_sub           = sa ^ sb ^ op_sub;
    s1_new.sign_big          = swap ? (sb ^ op_sub) : sa;
    s1_new.m_big             = swap ? sig_b : sig_a;
    s1_new.m_small_unshifted = swap ? sig_a : sig_b;
  end

  align_shift_sticky #(
    .W  (AL_W),
    .SW (EX_WIDTH + 1)
  ) u_shift (
    .in_val  ({r1_q.m_small_unshifted, {GRS_BITS{1'b0}}}),
    .sh      (r1_q.d),
    .out_val (aligned)
  );

  always_comb begin
    r1_d = load1 ? s1_new : r1_q;
    v1_d = load1 ? 1'b1 : (adv2 ? 1'b0 : v1_q);
    r2_d = r2_q;
    if (adv2) begin
      r2_d.e_big    = r1_q.e_big;
      r2_d.d        = r1_q.d;
      r2_d.swapped  = r1_q.swapped;
      r2_d.eff_sub  = r1_q.eff_sub;
      r2_d.sign_big = r1_q.sign_big;
      r2_d.m_big    = r1_q.m_big;
      r2_d.m_small  = aligned;
    end
    v2_d = adv2 ? 1'b1 : (out_ready ? 1'b0 : v2_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      r1_q   <= '0;
      r2_q   <= '0;
    end else begin
      init_q <= 1'b1;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      r1_q   <= r1_d;
      r2_q   <= r2_d;
    end
  end

  assign out_valid = v2_q;
  assign max_exp   = r2_q.e_big;
  assign d         = r2_q.d;
  assign swapped   = r2_q.swapped;
  assign eff_sub   = r2_q.eff_sub;
  assign sign_big  = r2_q.sign_big;
  assign m_big     = r2_q.m_big;
  assign m_small   = r2_q.m_small;

endmodule

// File: tb/tb_exp_align_pipe.sv
// Directed and randomized checks of exp_align_pipe against an arithmetic reference model.
module tb_exp_align_pipe;

  typedef struct packed {
    logic [7:0]  max_exp;
    logic [8:0]  d;
    logic        swapped;
    logic        eff_sub;
    logic        sign_big;
    logic [23:0] m_big;
    logic [26:0] m_small;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  ea = '0, eb = '0;
  logic [22:0] fa = '0, fb = '0;
  logic        sa = 1'b0, sb = 1'b0, op_sub = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [7:0]  max_exp;
  logic [8:0]  d;
  logic        swapped, eff_sub, sign_big;
  logic [23:0] m_big;
  logic [26:0] m_small;

  exp_align_pipe #(.EX_WIDTH(8), .MAN_WIDTH(23), .SWAP_ON_TIE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ea(ea), .eb(eb), .fa(fa), .fb(fb), .sa(sa), .sb(sb), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready), .max_exp(max_exp), .d(d),
    .swapped(swapped), .eff_sub(eff_sub), .sign_big(sign_big),
    .m_big(m_big), .m_small(m_small)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   n_out = 0;
  res_t sb_q[$];

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t got();
    return {max_exp, d, swapped, eff_sub, sign_big, m_big, m_small};
  endfunction

  // Reference: integer arithmetic straight from the ordering and alignment rules.
  function automatic res_t model(input logic [7:0] xa, input logic [7:0] xb,
                                 input logic [22:0] xfa, input logic [22:0] xfb,
                                 input logic xsa, input logic xsb, input logic xop);
    int     ea_i, eb_i, big_e, sml_e, dd;
    longint ma, mb, msml, full, al;
    bit     sw;
    res_t   r;
    ea_i  = (xa == 0) ? 1 : int'(xa);
    eb_i  = (xb == 0) ? 1 : int'(xb);
    ma    = ((xa != 0) ? longint'(1) << 23 : 0) + longint'(xfa);
    mb    = ((xb != 0) ? longint'(1) << 23 : 0) + longint'(xfb);
    sw    = (eb_i > ea_i) || (eb_i == ea_i && mb > ma);
    big_e = sw ? eb_i : ea_i;
    sml_e = sw ? ea_i : eb_i;
    dd    = big_e - sml_e;
    msml  = sw ? ma : mb;
    if (dd >= 27) begin
      al = (msml != 0) ? 1 : 0;
    end else begin
      full = msml * 8;
      al   = (full >> dd) | (((full % (longint'(1) << dd)) != 0) ? 1 : 0);
    end
    r.max_exp  = 8'(big_e);
    r.d        = 9'(dd);
    r.swapped  = sw;
    r.eff_sub  = xsa ^ xsb ^ xop;
    r.sign_big = sw ? (xsb ^ xop) : xsa;
    r.m_big    = 24'(sw ? mb : ma);
    r.m_small  = 27'(al);
    return r;
  endfunction

  task automatic tick(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      if (sb_q.size() == 0) check("spurious_out_valid", 80'(out_valid), 80'(0));
      else check("scoreboard", 80'(got()), 80'(sb_q.pop_front()));
    end
    if (acc) sb_q.push_back(model(ea, eb, fa, fb, sa, sb, op_sub));
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [7:0] a_e, input logic [7:0] b_e,
                          input logic [22:0] a_f, input logic [22:0] b_f,
                          input logic a_s, input logic b_s, input logic op, input res_t exp);
    bit acc;
    ea = a_e; eb = b_e; fa = a_f; fb = b_f; sa = a_s; sb = b_s; op_sub = op;
    in_valid = 1'b1; out_ready = 1'b1;
    tick(acc);
    check({tag, "_accept"}, 80'(acc), 80'(1));
    in_valid = 1'b0;
    check({tag, "_latency"}, 80'(out_valid), 80'(0));
    tick(acc);
    @(negedge clk);
    check({tag, "_valid"}, 80'(out_valid), 80'(1));
    check(tag, 80'(got()), 80'(exp));
    if (sb_q.size() != 0) check({tag, "_model"}, 80'(got()), 80'(sb_q.pop_front()));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rnd_exp();
    case ($urandom_range(0, 6))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'hFE;
      3: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic rnd_operands();
    ea = rnd_exp();
    if ($urandom_range(0, 2) == 0) eb = 8'(int'(ea) + $urandom_range(0, 60) - 30);
    else eb = rnd_exp();
    fa = 23'($urandom);
    fb = ($urandom_range(0, 7) == 0) ? fa : 23'($urandom);
    if ($urandom_range(0, 7) == 0) fb = 23'($urandom_range(0, 15));
    sa = 1'($urandom); sb = 1'($urandom); op_sub = 1'($urandom);
  endtask

  initial begin
    bit acc;
    bit saw_stall;
    int p;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 80'(out_valid), 80'(0));
    check("rst_in_ready", 80'(in_ready), 80'(0));
    check("rst_data", 80'(got()), 80'(0));
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", 80'(in_ready), 80'(0));
    @(posedge clk);
    #1;
    check("in_ready_after_edge", 80'(in_ready), 80'(1));

    // Directed cases
    directed("normal", 8'h82, 8'h80, 23'h0, 23'h400001, 1'b0, 1'b0, 1'b0,
             '{max_exp: 8'h82, d: 9'd2, swapped: 1'b0, eff_sub: 1'b0, sign_big: 1'b0,
               m_big: 24'h800000, m_small: 27'h1800002});
    directed("tie_swap", 8'h7F, 8'h7F, 23'h100000, 23'h200000, 1'b0, 1'b1, 1'b0,
             '{max_exp: 8'h7F, d: 9'd0, swapped: 1'b1, eff_sub: 1'b1, sign_big: 1'b1,
               m_big: 24'hA00000, m_small: 27'h4800000});
    directed("denormal", 8'h00, 8'h01, 23'h123, 23'h0, 1'b1, 1'b0, 1'b1,
             '{max_exp: 8'h01, d: 9'd0, swapped: 1'b1, eff_sub: 1'b0, sign_big: 1'b1,
               m_big: 24'h800000, m_small: 27'h918});
    directed("saturate", 8'hFE, 8'h01, 23'h0, 23'h5, 1'b0, 1'b0, 1'b1,
             '{max_exp: 8'hFE, d: 9'hFD, swapped: 1'b0, eff_sub: 1'b1, sign_big: 1'b0,
               m_big: 24'h800000, m_small: 27'h1});
    directed("d27_edge", 8'h1C, 8'h01, 23'h0, 23'h4, 1'b0, 1'b0, 1'b0,
             '{max_exp: 8'h1C, d: 9'd27, swapped: 1'b0, eff_sub: 1'b0, sign_big: 1'b0,
               m_big: 24'h800000, m_small: 27'h1});
    directed("d24_sticky", 8'h19, 8'h01, 23'h0, 23'h1, 1'b0, 1'b0, 1'b0,
             '{max_exp: 8'h19, d: 9'd24, swapped: 1'b0, eff_sub: 1'b0, sign_big: 1'b0,
               m_big: 24'h800000, m_small: 27'h5});
    directed("equal_mag", 8'h40, 8'h40, 23'h1234, 23'h1234, 1'b1, 1'b1, 1'b0,
             '{max_exp: 8'h40, d: 9'd0, swapped: 1'b0, eff_sub: 1'b0, sign_big: 1'b1,
               m_big: 24'h801234, m_small: 27'h40091A0});

    // Backpressure: 5 back-to-back pairs, sink stalled in cycles 3-6
    n_out = 0; p = 0; saw_stall = 1'b0;
    for (int c = 0; c < 40 && (p < 5 || sb_q.size() > 0); c++) begin
      out_ready = !(c >= 3 && c <= 6);
      if (p < 5) begin
        in_valid = 1'b1; rnd_operands();
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready) saw_stall = 1'b1;
      tick(acc);
      if (acc) p++;
    end
    check("bp_in_ready_dropped", 80'(saw_stall), 80'(1));
    check("bp_outputs", 80'(n_out), 80'(5));
    check("bp_drained", 80'(sb_q.size()), 80'(0));

    // Reset with two pairs in flight
    out_ready = 1'b1;
    in_valid = 1'b1; rnd_operands(); tick(acc);
    rnd_operands(); tick(acc);
    in_valid = 1'b0;
    check("pre_reset_out_valid", 80'(out_valid), 80'(1));
    rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", 80'(out_valid), 80'(0));
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_out = 0;
    repeat (8) tick(acc);
    check("post_reset_no_output", 80'(n_out), 80'(0));

    // Random traffic with random backpressure
    n_out = 0; p = 0;
    for (int c = 0; c < 60000 && (p < 10000 || sb_q.size() > 0); c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if (p < 10000 && $urandom_range(0, 9) < 8) begin
        in_valid = 1'b1; rnd_operands();
      end else begin
        in_valid = 1'b0;
      end
      tick(acc);
      if (acc) p++;
    end
    check("rand_accepted", 80'(p), 80'(10000));
    check("rand_outputs", 80'(n_out), 80'(10000));
    check("rand_drained", 80'(sb_q.size()), 80'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
